// File: rtl/mc_control_unit_if.sv
// Control-unit bus: instruction fields and handshakes in, control bundle out.
// mem_ready completes a request when it is high in a cycle where memRead or
// memWrite is asserted; the request and iorD hold unchanged until that cycle.
// mul_done completes a multiply/divide started by the one-cycle mulStart pulse.
interface mc_control_unit_if;
  logic [6:0] opCode;
  logic       funct7_0;
  logic       mem_ready;
  logic       mul_done;

  logic       pcWrite;
  logic       irWrite;
  logic       memRead;
  logic       memWrite;
  logic       iorD;
  logic       regWrite;
  logic       memtoReg;
  logic       writeSrc;
  logic       aluSrc1;
  logic       jump;
  logic       jumpReg;
  logic       branch;
  logic       mulStart;
  logic [1:0] aluSrc2;
  logic [1:0] aluOp;

  modport master (
    input  opCode, funct7_0, mem_ready, mul_done,
    output pcWrite, irWrite, memRead, memWrite, iorD, regWrite, memtoReg,
           writeSrc, aluSrc1, jump, jumpReg, branch, mulStart, aluSrc2, aluOp
  );

  modport slave (
    output opCode, funct7_0, mem_ready, mul_done,
    input  pcWrite, irWrite, memRead, memWrite, iorD, regWrite, memtoReg,
           writeSrc, aluSrc1, jump, jumpReg, branch, mulStart, aluSrc2, aluOp
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/write-back with
// memory and multiplier handshakes, retired-instruction counter and trap state.
module mc_control_unit #(
  parameter bit ENABLE_MUL = 1'b0,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  mc_control_unit_if.master bus,
  output logic              illegal,
  output logic [CNT_W-1:0]  instret,
  output logic [3:0]        state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    EXEC_U   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_ALU   = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11,
    JALR     = 4'd12,
    MUL_WAIT = 4'd13,
    TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic       pcWrite;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       regWrite;
    logic       memtoReg;
    logic       writeSrc;
    logic       aluSrc1;
    logic       jump;
    logic       jumpReg;
    logic       branch;
    logic       mulStart;
    logic [1:0] aluSrc2;
    logic [1:0] aluOp;
  } ctl_t;

  state_t state, state_next;
  ctl_t   ctl, ctl_out;
  logic   retire;
  logic   is_mul;

  assign is_mul = ENABLE_MUL && bus.funct7_0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    ctl        = '0;
    case (state)
      FETCH: begin
        ctl.memRead = 1'b1;
        ctl.aluSrc1 = 1'b1;
        ctl.aluSrc2 = 2'b10;
        if (bus.mem_ready) begin
          ctl.irWrite = 1'b1;
          ctl.pcWrite = 1'b1;
          state_next  = DECODE;
        end
      end
      DECODE: begin
        case (bus.opCode)
          OP_R:              state_next = (bus.funct7_0 && !ENABLE_MUL) ? TRAP : EXEC_R;
          OP_I:              state_next = EXEC_I;
          OP_LUI, OP_AUIPC:  state_next = EXEC_U;
          OP_LOAD, OP_STORE: state_next = MEM_ADDR;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          OP_JALR:           state_next = JALR;
          default:           state_next = TRAP;
        endcase
      end
      EXEC_R: begin
        ctl.aluOp    = 2'b10;
        ctl.mulStart = is_mul;
        state_next   = is_mul ? MUL_WAIT : WB_ALU;
      end
      EXEC_I: begin
        ctl.aluSrc2 = 2'b01;
        ctl.aluOp   = 2'b11;
        state_next  = WB_ALU;
      end
      EXEC_U: begin
        // AUIPC (opCode[5]==0) adds to the old PC, LUI passes the immediate.
        ctl.aluSrc1 = ~bus.opCode[5];
        ctl.aluSrc2 = 2'b11;
        state_next  = WB_ALU;
      end
      MEM_ADDR: begin
        ctl.aluSrc2 = 2'b01;
        state_next  = bus.opCode[5] ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        ctl.memRead = 1'b1;
        ctl.iorD    = 1'b1;
        if (bus.mem_ready) state_next = WB_MEM;
      end
      MEM_WR: begin
        ctl.memWrite = 1'b1;
        ctl.iorD     = 1'b1;
        if (bus.mem_ready) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      MUL_WAIT: begin
        if (bus.mul_done) state_next = WB_ALU;
      end
      WB_ALU: begin
        ctl.regWrite = 1'b1;
        state_next   = FETCH;
        retire       = 1'b1;
      end
      WB_MEM: begin
        ctl.regWrite = 1'b1;
        ctl.memtoReg = 1'b1;
        state_next   = FETCH;
        retire       = 1'b1;
      end
      BRANCH: begin
        ctl.branch = 1'b1;
        ctl.aluOp  = 2'b01;
        state_next = FETCH;
        retire     = 1'b1;
      end
      JAL, JALR: begin
        ctl.jump     = (state == JAL);
        ctl.jumpReg  = (state == JALR);
        ctl.aluSrc1  = (state == JAL);
        ctl.regWrite = 1'b1;
        ctl.writeSrc = 1'b1;
        ctl.aluSrc2  = 2'b01;
        ctl.pcWrite  = 1'b1;
        state_next   = FETCH;
        retire       = 1'b1;
      end
      TRAP:    state_next = TRAP;
      default: state_next = TRAP;
    endcase
  end

  // Controls are forced low in the reset cycle so nothing reaches the datapath.
  assign ctl_out = rst ? '0 : ctl;

  assign bus.pcWrite  = ctl_out.pcWrite;
  assign bus.irWrite  = ctl_out.irWrite;
  assign bus.memRead  = ctl_out.memRead;
  assign bus.memWrite = ctl_out.memWrite;
  assign bus.iorD     = ctl_out.iorD;
  assign bus.regWrite = ctl_out.regWrite;
  assign bus.memtoReg = ctl_out.memtoReg;
  assign bus.writeSrc = ctl_out.writeSrc;
  assign bus.aluSrc1  = ctl_out.aluSrc1;
  assign bus.jump     = ctl_out.jump;
  assign bus.jumpReg  = ctl_out.jumpReg;
  assign bus.branch   = ctl_out.branch;
  assign bus.mulStart = ctl_out.mulStart;
  assign bus.aluSrc2  = ctl_out.aluSrc2;
  assign bus.aluOp    = ctl_out.aluOp;

  assign illegal = (state == TRAP) && !rst;
  assign state_o = state;

endmodule
